// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//
// Purpose:
//   Tracks the destination registers of instructions in flight after ID
//   (stage 1 = EX ... stage DEPTH = WB). It chooses a forwarding source for
//   each of the two ID operands. It stalls ID when the youngest producer of an
//   operand is a load whose data is not yet available.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   id_valid              ID holds a real instruction
//   rs_id, rt_id          ID source registers; use_rs/use_rt qualify them
//   id_rd, id_wen         ID destination register and its write enable
//   id_is_load            ID instruction is a load
//   flush                 kill the ID instruction and the stage-1 entry
//   stall                 hold PC and ID (combinational)
//   fwd_a, fwd_b          0 = register file, k = forward from stage k
//   stall_count           saturating count of stalled cycles
//
// Qualifier semantics: an ID instruction enters stage 1 only in a cycle where
// id_valid=1, stall=0 and flush=0. Every other cycle inserts a bubble.
module forward_hazard_unit #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    rs_id,
  input  logic [AW-1:0]    rt_id,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [15:0]      stall_count
);

  // Per-stage producer records, index k = stage k.
  logic [DEPTH:1]  valid_q, valid_d;
  logic [DEPTH:1]  wen_q,   wen_d;
  logic [DEPTH:1]  load_q,  load_d;
  logic [AW-1:0]   rd_q [1:DEPTH];
  logic [AW-1:0]   rd_d [1:DEPTH];
  logic [15:0]     stall_count_q, stall_count_d;

  int   win_a, win_b;
  logic haz_a, haz_b;

  // Operand resolution. The scan runs from oldest to youngest, so the last
  // hit it records is the youngest producer. That producer wins.
  always_comb begin
    win_a = 0;
    win_b = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_q[k] && wen_q[k] && (rd_q[k] != '0)) begin
        if (use_rs && (rd_q[k] == rs_id)) win_a = k;
        if (use_rt && (rd_q[k] == rt_id)) win_b = k;
      end
    end
    // A load that has not yet reached LOAD_STAGE cannot supply data.
    haz_a = (win_a != 0) && load_q[win_a] && (win_a < LOAD_STAGE);
    haz_b = (win_b != 0) && load_q[win_b] && (win_b < LOAD_STAGE);
  end

  assign fwd_a       = haz_a ? '0 : SEL_W'(win_a);
  assign fwd_b       = haz_b ? '0 : SEL_W'(win_b);
  // Flush kills the ID instruction, so its hazard is irrelevant.
  assign stall       = (haz_a || haz_b) && id_valid && !flush;
  assign stall_count = stall_count_q;

  // Next state: shift the pipeline by one stage every cycle.
  always_comb begin
    valid_d[1] = id_valid && !stall && !flush;
    wen_d[1]   = id_wen;
    load_d[1]  = id_is_load;
    rd_d[1]    = id_rd;
    for (int k = 2; k <= DEPTH; k++) begin
      // Flush also kills the instruction leaving stage 1.
      valid_d[k] = valid_q[k-1] && !(flush && (k == 2));
      wen_d[k]   = wen_q[k-1];
      load_d[k]  = load_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= '0;
      wen_q         <= '0;
      load_q        <= '0;
      stall_count_q <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      valid_q       <= valid_d;
      wen_q         <= wen_d;
      load_q        <= load_d;
      stall_count_q <= stall_count_d;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Testbench for forward_hazard_unit with DEPTH=3 and LOAD_STAGE=2.
// The driver applies stimulus and pushes the expected outputs from a
// reference model of the in-flight producers. The monitor pops the queue
// and compares mid-cycle.
module tb_forward_hazard_unit;
  localparam int AW = 5, DEPTH = 3, LOAD_STAGE = 2, SEL_W = 2;
  localparam int W = 1 + 2*SEL_W + 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, use_rs = 1'b0, use_rt = 1'b0;
  logic id_wen = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [AW-1:0] rs_id = '0, rt_id = '0, id_rd = '0;
  logic stall;
  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  forward_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs(use_rs), .use_rt(use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_count(stall_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic          wen;
    logic          ld;
  } prod_t;

  prod_t pipe [DEPTH];          // pipe[k-1] is the producer k stages past ID
  int unsigned m_cnt = 0;
  logic exp_stall = 1'b0;
  logic [W-1:0] exp_q[$];
  string phase = "reset";
  int checks = 0, failures = 0;

  // Youngest in-flight writer of src (0 = none / register file).
  function automatic int youngest_writer(input logic [AW-1:0] src, input logic used);
    if (!used || src == '0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (pipe[k-1].v && pipe[k-1].wen && pipe[k-1].rd == src) return k;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [AW-1:0] rd, input logic wen, input logic ld,
                        input logic [AW-1:0] rs, input logic urs,
                        input logic [AW-1:0] rt, input logic urt);
    id_valid = v; id_rd = rd; id_wen = wen; id_is_load = ld;
    rs_id = rs; use_rs = urs; rt_id = rt; use_rt = urt;
  endtask

  task automatic idle();
    set_id(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Called a little after a rising edge with the inputs already applied.
  // It predicts this cycle's outputs, then advances the model across the next edge.
  task automatic cycle();
    int ka, kb;
    logic ha, hb, st;
    logic [SEL_W-1:0] fa, fb;
    ka = youngest_writer(rs_id, use_rs);
    kb = youngest_writer(rt_id, use_rt);
    ha = (ka != 0) && pipe[ka-1].ld && (ka < LOAD_STAGE);
    hb = (kb != 0) && pipe[kb-1].ld && (kb < LOAD_STAGE);
    fa = ha ? '0 : SEL_W'(ka);
    fb = hb ? '0 : SEL_W'(kb);
    st = (ha || hb) && id_valid && !flush;
    exp_q.push_back({st, fa, fb, m_cnt[15:0]});
    exp_stall = st;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe[k].v = 1'b0;
      m_cnt = 0;
    end else begin
      if (st && m_cnt < 32'hFFFF) m_cnt++;
      for (int k = DEPTH-1; k >= 1; k--) pipe[k] = pipe[k-1];
      if (flush) pipe[1].v = 1'b0;
      pipe[0] = '{v: id_valid && !st && !flush, rd: id_rd, wen: id_wen, ld: id_is_load};
    end
    #2;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Load of rd followed by a consumer of rd. The consumer is held through its stall.
  task automatic load_use(input logic [AW-1:0] rd);
    set_id(1'b1, rd, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    cycle();
    set_id(1'b1, 5'd1, 1'b1, 1'b0, rd, 1'b1, '0, 1'b0);
    cycle();
    cycle();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {stall, fwd_a, fwd_b, stall_count};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL %s t=%0t got stall=%0b fwd_a=%0d fwd_b=%0d cnt=%h expected stall=%0b fwd_a=%0d fwd_b=%0d cnt=%h",
                   phase, $time, act_v[W-1], act_v[W-2 -: SEL_W], act_v[W-2-SEL_W -: SEL_W], act_v[15:0],
                   exp_v[W-1], exp_v[W-2 -: SEL_W], exp_v[W-2-SEL_W -: SEL_W], exp_v[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int drain;
    for (int k = 0; k < DEPTH; k++) pipe[k] = '{v: 1'b0, rd: '0, wen: 1'b0, ld: 1'b0};
    // The first reset edge establishes a known state; it is not checked.
    @(posedge clk); #2;
    phase = "reset";
    idle(); flush = 1'b1;
    cycle();                                   // still in reset, flush asserted
    flush = 1'b0; rst_n = 1'b1;
    cycle();

    phase = "alu_b2b";
    set_id(1'b1, 5'd5, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd6, 1'b0, 1'b0, 5'd5, 1'b1, '0, 1'b0); cycle();   // fwd_a=1
    cycle();                                                          // fwd_a=2
    idle_cycles(3);

    phase = "load_use";
    set_id(1'b1, 5'd8, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, '0, 1'b0, 5'd8, 1'b1); cycle();   // stall
    cycle();                                                          // fwd_b=2, cnt=1
    idle_cycles(3);

    phase = "priority_zero";
    set_id(1'b1, 5'd3, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd7, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd3, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1); cycle(); // fwd_a=fwd_b=1
    set_id(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, '0, 1'b0); cycle();   // r0 not forwarded
    idle_cycles(3);

    phase = "flush_hazard";
    set_id(1'b1, 5'd4, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 1'b1, '0, 1'b0); flush = 1'b1; cycle();
    flush = 1'b0;
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1); cycle(); // load gone
    idle_cycles(3);

    phase = "reset_mid_stall";
    for (int i = 0; i < 6; i++) load_use(5'd10);                     // count reaches 7
    idle_cycles(2);
    set_id(1'b1, 5'd11, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0); cycle();
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd11, 1'b1, '0, 1'b0);
    rst_n = 1'b0; cycle();                                            // stall=1, cnt=7
    rst_n = 1'b1; cycle(); cycle();                                   // no stall
    idle_cycles(2);

    phase = "saturation";
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    m_cnt = 32'hFFFE;
    for (int i = 0; i < 3; i++) load_use(5'd13);
    idle_cycles(2);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      if (!exp_stall)
        set_id(1'($urandom_range(0, 4) != 0), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      cycle();
    end
    flush = 1'b0; rst_n = 1'b1;
    idle_cycles(2);

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(negedge clk); drain++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked producer stages after ID (stage 1 = EX ... stage DEPTH = WB).
REQ-003 SHALL have parameter LOAD_STAGE, default 2, first stage index at which load data is forwardable; legal range 1..DEPTH.
REQ-004 SHALL have parameter SEL_W, default 2, forward-select width; the integrator sets it to ceil(log2(DEPTH+1)).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 id_valid  input  1  ID stage holds a real instruction.
REQ-008 rs_id, rt_id  input  AW each  source register addresses in ID.
REQ-009 use_rs, use_rt  input  1 each  the ID instruction actually reads rs or rt.
REQ-010 id_rd  input  AW  destination register of the ID instruction.
REQ-011 id_wen  input  1  the ID instruction writes id_rd.
REQ-012 id_is_load  input  1  the ID instruction is a load.
REQ-013 flush  input  1  kill the ID instruction and the stage-1 entry.
REQ-014 stall  output  1  hold PC and ID; combinational.
REQ-015 fwd_a, fwd_b  output  SEL_W each  operand source: 0 = register file, k = stage k; combinational.
REQ-016 stall_count  output  16  saturating count of stall cycles.

Function
REQ-017 SHALL keep one entry per stage k = 1..DEPTH holding {valid, rd, wen, is_load}.
REQ-018 Each cycle, stage k+1 SHALL load stage k for k = 1..DEPTH-1, and the stage-DEPTH entry SHALL be discarded.
REQ-019 Stage 1 SHALL load the ID fields when id_valid=1, stall=0 and flush=0; otherwise stage 1 SHALL load a bubble (valid=0).
REQ-020 When flush=1, stage 2 SHALL load a bubble instead of stage 1.
REQ-021 Stage k SHALL match operand src when valid=1, wen=1, rd==src, rd!=0 and the operand's use bit is 1.
REQ-022 Among matching stages, the smallest k (youngest producer) SHALL win.
REQ-023 If the winning stage has is_load=1 and k<LOAD_STAGE, that operand SHALL raise a hazard and its fwd SHALL be 0.
REQ-024 Otherwise, fwd SHALL equal the winning k.
REQ-025 With no matching stage, fwd SHALL be 0.
REQ-026 stall SHALL be (hazard_a OR hazard_b) AND id_valid AND NOT flush.
REQ-027 A load SHALL stall a dependent ID instruction for exactly LOAD_STAGE-1 cycles; back-to-back stalls for the same load SHALL be allowed.
REQ-028 A single entry matching both rs and rt SHALL drive both fwd_a and fwd_b.
REQ-029 stall_count SHALL increment by 1 on each rising edge where stall=1.
REQ-030 stall_count SHALL saturate at 16'hFFFF.
REQ-031 When flush and a hazard coincide, flush SHALL win: stall=0 and stall_count SHALL not increment.

Reset
REQ-032 On a rising edge with rst_n=0, all entries SHALL become invalid and stall_count SHALL become 0.
REQ-033 In the cycle after reset, stall SHALL be 0 and fwd_a/fwd_b SHALL be 0.
REQ-034 Reset SHALL override flush and stall.
REQ-035 Reset mid-stall SHALL discard the pending load; no stall SHALL appear after release.

Verification (DEPTH=3, LOAD_STAGE=2)
REQ-036 Back-to-back ALU: cycle 0 ID = {rd=5, wen=1}; cycle 1 ID rs=5, use_rs=1 -> fwd_a=1, stall=0; cycle 2 same rs -> fwd_a=2.
REQ-037 Load-use: cycle 0 ID = {rd=8, load}; cycle 1 ID rt=8, use_rt=1 -> stall=1, fwd_b=0; cycle 2 -> stall=0, fwd_b=2, stall_count=1.
REQ-038 Priority and zero register: rd=3 in stages 1 and 3 with rs=3 -> fwd_a=1; producer rd=0, wen=1, rs=0 -> fwd_a=0.
REQ-039 Flush during hazard: load rd=4 in stage 1, ID rs=4, flush=1 -> stall=0, stall_count unchanged; next cycle stages 1 and 2 invalid.
REQ-040 Reset mid-operation: rst_n=0 for one edge while stall=1 and stall_count=7 -> stall_count=0, stall=0, fwd_a=fwd_b=0.
REQ-041 Saturation: force stall_count=16'hFFFE, then hold a hazard for 3 cycles -> stall_count reads FFFF and stays FFFF.
